// File: rtl/piano_tone_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : piano_tone_arbiter                                         |
// | Description : Fixed-priority beeper arbiter (chirp > manual > song) with |
// |               a silent gap on hand-over and song beat freeze.            |
// |               Optional ARB_HOLD_EN enforces minimum manual ownership.    |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module piano_tone_arbiter #(
  parameter int                NOTE_W       = 5,
  parameter int                GAP_CYC      = 12000,
  parameter int                CHIRP_CYC    = 600000,
  parameter logic [NOTE_W-1:0] CHIRP_NOTE   = NOTE_W'(15),
  parameter int                MIN_HOLD_CYC = 1200000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              chirp_trig,
  input  logic              key_valid,
  input  logic [NOTE_W-1:0] key_note,
  input  logic              song_req,
  input  logic [NOTE_W-1:0] song_note,
  output logic              tone_en,
  output logic [NOTE_W-1:0] tone_note,
  output logic [1:0]        owner,
  output logic              song_pause,
  output logic              busy
);

  localparam int c_MAX_GC = (GAP_CYC > CHIRP_CYC) ? GAP_CYC : CHIRP_CYC;
`ifdef ARB_HOLD_EN
  localparam bit c_HOLD_EN = 1'b1;
  localparam int c_MAX_CYC = (MIN_HOLD_CYC > c_MAX_GC) ? MIN_HOLD_CYC : c_MAX_GC;
`else
  localparam bit c_HOLD_EN = 1'b0;
  localparam int c_MAX_CYC = c_MAX_GC;
`endif
  localparam int                 c_CNT_W      = (c_MAX_CYC > 2) ? $clog2(c_MAX_CYC) : 1;
  localparam logic [c_CNT_W-1:0] c_CNT_SAT    = c_CNT_W'(c_MAX_CYC - 1);
  localparam logic [c_CNT_W-1:0] c_GAP_LAST   = c_CNT_W'(GAP_CYC - 1);
  localparam logic [c_CNT_W-1:0] c_CHIRP_LAST = c_CNT_W'(CHIRP_CYC - 1);
  localparam logic [c_CNT_W-1:0] c_HOLD_LAST  = c_CNT_W'(MIN_HOLD_CYC - 1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_GAP    = 3'd1,
    ST_CHIRP  = 3'd2,
    ST_MANUAL = 3'd3,
    ST_SONG   = 3'd4
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  state_t              w_win;
  logic [c_CNT_W-1:0]  r_cnt;
  logic [c_CNT_W-1:0]  w_cnt_nxt;
  logic                r_chirp_pending;
  logic                w_pend_nxt;
  logic                w_retrig;
  logic                w_hold;
  logic                r_tone_en;
  logic                w_tone_en_nxt;
  logic [NOTE_W-1:0]   r_tone_note;
  logic [NOTE_W-1:0]   w_tone_note_nxt;
  logic [1:0]          r_owner;
  logic [1:0]          w_owner_nxt;
  logic                r_song_pause;
  logic                r_busy;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state         <= ST_IDLE;
      r_cnt           <= '0;
      r_chirp_pending <= 1'b0;
      r_tone_en       <= 1'b0;
      r_tone_note     <= '0;
      r_owner         <= 2'd0;
      r_song_pause    <= 1'b0;
      r_busy          <= 1'b0;
    end else begin
      r_state         <= w_state_nxt;
      r_cnt           <= w_cnt_nxt;
      r_chirp_pending <= w_pend_nxt;
      r_tone_en       <= w_tone_en_nxt;
      r_tone_note     <= w_tone_note_nxt;
      r_owner         <= w_owner_nxt;
      r_song_pause    <= song_req && (w_state_nxt != ST_SONG);
      r_busy          <= (w_state_nxt != ST_IDLE);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_retrig    = 1'b0;
    w_hold      = c_HOLD_EN && (r_cnt < c_HOLD_LAST);

    // Winner used whenever the beeper is silent (IDLE or last gap cycle)
    if (r_chirp_pending || chirp_trig) w_win = ST_CHIRP;
    else if (key_valid)                w_win = ST_MANUAL;
    else if (song_req)                 w_win = ST_SONG;
    else                               w_win = ST_IDLE;

    case (r_state)
      ST_IDLE: w_state_nxt = w_win;
      ST_GAP: begin
        if (r_cnt == c_GAP_LAST) w_state_nxt = w_win;
      end
      ST_CHIRP: begin
        if (chirp_trig) w_retrig = 1'b1;
        else if (r_cnt == c_CHIRP_LAST)
          w_state_nxt = (key_valid || song_req) ? ST_GAP : ST_IDLE;
      end
      ST_MANUAL: begin
        if (chirp_trig) w_state_nxt = ST_GAP;
        else if (!key_valid && !w_hold)
          w_state_nxt = song_req ? ST_GAP : ST_IDLE;
      end
      ST_SONG: begin
        if (chirp_trig || key_valid) w_state_nxt = ST_GAP;
        else if (!song_req)          w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase

    if ((w_state_nxt != r_state) || w_retrig) w_cnt_nxt = '0;
    else if (r_cnt == c_CNT_SAT)              w_cnt_nxt = r_cnt;
    else                                      w_cnt_nxt = r_cnt + c_CNT_W'(1);

    if ((r_state == ST_CHIRP) && (w_state_nxt != ST_CHIRP)) w_pend_nxt = 1'b0;
    else w_pend_nxt = r_chirp_pending || chirp_trig;

    w_tone_en_nxt   = 1'b0;
    w_tone_note_nxt = '0;
    w_owner_nxt     = 2'd0;
    case (w_state_nxt)
      ST_GAP: w_tone_note_nxt = r_tone_note;
      ST_CHIRP: begin
        w_tone_en_nxt   = 1'b1;
        w_tone_note_nxt = CHIRP_NOTE;
        w_owner_nxt     = 2'd3;
      end
      ST_MANUAL: begin
        // A released key inside the hold window keeps ownership silently
        w_owner_nxt = 2'd2;
        if (key_valid) begin
          w_tone_note_nxt = key_note;
          w_tone_en_nxt   = |key_note;
        end
      end
      ST_SONG: begin
        w_owner_nxt     = 2'd1;
        w_tone_note_nxt = song_note;
        w_tone_en_nxt   = |song_note;
      end
      default: ;
    endcase
  end

  assign tone_en    = r_tone_en;
  assign tone_note  = r_tone_note;
  assign owner      = r_owner;
  assign song_pause = r_song_pause;
  assign busy       = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_piano_tone_arbiter.sv
`default_nettype none
// Testbench for piano_tone_arbiter: directed scenarios plus random traffic,
// compared each cycle against a countdown-based ownership model.
module tb_piano_tone_arbiter;

  localparam int         GAP_CYC      = 4;
  localparam int         CHIRP_CYC    = 10;
  localparam int         MIN_HOLD_CYC = 20;
  localparam logic [4:0] CHIRP_NOTE   = 5'd15;
`ifdef ARB_HOLD_EN
  localparam bit HOLD_EN = 1'b1;
`else
  localparam bit HOLD_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       chirp_trig = 1'b0;
  logic       key_valid = 1'b0;
  logic [4:0] key_note = 5'd0;
  logic       song_req = 1'b0;
  logic [4:0] song_note = 5'd0;
  logic       tone_en;
  logic [4:0] tone_note;
  logic [1:0] owner;
  logic       song_pause;
  logic       busy;

  piano_tone_arbiter #(
    .NOTE_W      (5),
    .GAP_CYC     (GAP_CYC),
    .CHIRP_CYC   (CHIRP_CYC),
    .CHIRP_NOTE  (CHIRP_NOTE),
    .MIN_HOLD_CYC(MIN_HOLD_CYC)
  ) u_dut (
    .clk       (clk),
    .rst       (rst),
    .chirp_trig(chirp_trig),
    .key_valid (key_valid),
    .key_note  (key_note),
    .song_req  (song_req),
    .song_note (song_note),
    .tone_en   (tone_en),
    .tone_note (tone_note),
    .owner     (owner),
    .song_pause(song_pause),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, got, exp);
    end
  endtask

  // Model: who owns the beeper, how many silent gap cycles remain, how many
  // chirp cycles remain, and how long the manual player has held it.
  int         m_own;
  int         m_gap;
  int         m_left;
  int         m_age;
  bit         m_pend;
  bit         e_en;
  logic [4:0] e_note;
  int         e_own;
  bit         e_pause;
  bit         e_busy;

  task automatic model_reset();
    m_own = 0; m_gap = 0; m_left = 0; m_age = 0; m_pend = 0;
    e_en = 0; e_note = 5'd0; e_own = 0; e_pause = 0; e_busy = 0;
  endtask

  task automatic enter(input int who);
    m_own = who;
    if (who == 3) m_left = CHIRP_CYC;
    if (who == 2) m_age = 0;
  endtask

  task automatic start_gap();
    m_own = 0;
    m_gap = GAP_CYC;
  endtask

  task automatic model_step();
    int w;
    bit chirp_done;
    chirp_done = 0;
    if (m_pend || chirp_trig) w = 3;
    else if (key_valid)       w = 2;
    else if (song_req)        w = 1;
    else                      w = 0;

    if (m_gap > 0) begin
      if (m_gap == 1) begin m_gap = 0; enter(w); end
      else m_gap--;
    end else begin
      case (m_own)
        0: enter(w);
        3: begin
          if (chirp_trig) m_left = CHIRP_CYC;
          else if (m_left == 1) begin
            chirp_done = 1;
            if (key_valid || song_req) start_gap(); else m_own = 0;
          end else m_left--;
        end
        2: begin
          if (chirp_trig) start_gap();
          else if (!key_valid && !(HOLD_EN && m_age < MIN_HOLD_CYC - 1)) begin
            if (song_req) start_gap(); else m_own = 0;
          end else m_age++;
        end
        default: begin
          if (chirp_trig || key_valid) start_gap();
          else if (!song_req) m_own = 0;
        end
      endcase
    end
    m_pend = chirp_done ? 1'b0 : (m_pend | chirp_trig);

    if (m_gap > 0) begin
      e_en = 0;
    end else begin
      case (m_own)
        0: begin e_en = 0; e_note = 5'd0; end
        1: begin e_note = song_note; e_en = (song_note != 0); end
        2: begin e_note = key_valid ? key_note : 5'd0; e_en = key_valid && (key_note != 0); end
        default: begin e_note = CHIRP_NOTE; e_en = 1; end
      endcase
    end
    e_own   = (m_gap > 0) ? 0 : m_own;
    e_busy  = (m_gap > 0) || (m_own != 0);
    e_pause = song_req && !((m_gap == 0) && (m_own == 1));
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    check_eq("tone_en", 32'(tone_en), 32'(e_en));
    check_eq("tone_note", 32'(tone_note), 32'(e_note));
    check_eq("owner", 32'(owner), 32'(e_own));
    check_eq("song_pause", 32'(song_pause), 32'(e_pause));
    check_eq("busy", 32'(busy), 32'(e_busy));
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_tone_en", 32'(tone_en), 32'd0);
    check_eq("rst_owner", 32'(owner), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    cycles(2);

    // Manual key from idle, then release
    key_valid = 1; key_note = 5'd3;
    cycle();
    check_eq("key_owner", 32'(owner), 32'd2);
    check_eq("key_note", 32'(tone_note), 32'd3);
    key_valid = 0;
    cycles(3);

    // Song preempted by a key, then resumed after release
    song_req = 1; song_note = 5'd7;
    cycles(3);
    key_valid = 1; key_note = 5'd1;
    cycles(6);
    key_valid = 0;
    cycles(7);

    // Chirp preempts manual; retrigger during chirp
    key_valid = 1; key_note = 5'd5;
    cycles(3);
    chirp_trig = 1; cycle(); chirp_trig = 0;
    cycles(GAP_CYC + 6);
    chirp_trig = 1; cycle(); chirp_trig = 0;
    cycles(14);
    key_valid = 0;
    cycles(8);

    // Chirp and key together from idle
    song_req = 0;
    cycles(6);
    chirp_trig = 1; key_valid = 1; key_note = 5'd9;
    cycle();
    chirp_trig = 0;
    cycles(20);
    key_valid = 0;
    cycles(4);

    // Short key press: minimum hold (if built in) or immediate release
    key_valid = 1; key_note = 5'd4;
    cycles(3);
    key_valid = 0;
    cycles(25);

    // Asynchronous reset in the middle of a chirp
    song_req = 1; song_note = 5'd2;
    cycles(GAP_CYC + 4);
    chirp_trig = 1; cycle(); chirp_trig = 0;
    cycles(GAP_CYC + 5);
    #3 rst = 1'b1;
    #1;
    check_eq("arst_tone_en", 32'(tone_en), 32'd0);
    check_eq("arst_owner", 32'(owner), 32'd0);
    check_eq("arst_song_pause", 32'(song_pause), 32'd0);
    check_eq("arst_busy", 32'(busy), 32'd0);
    song_req = 0; key_valid = 0;
    @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
    cycles(CHIRP_CYC + 4);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      chirp_trig = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 9) == 0)  key_valid = ~key_valid;
      if ($urandom_range(0, 19) == 0) song_req  = ~song_req;
      if ($urandom_range(0, 3) == 0)  key_note  = 5'($urandom_range(0, 31));
      if ($urandom_range(0, 3) == 0)  song_note = 5'($urandom_range(0, 31));
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/piano_tone_arbiter.md
Name: piano_tone_arbiter

Overview:
Arbitrates the piano's single tone generator/beeper between three requesters:
- mode-change confirmation chirp
- manual keypad notes
- auto-play song sequencer

Enforces fixed priority (chirp > manual > song) and inserts a silent gap on every owner hand-over to avoid clicks. Freezes the song sequencer's beat timing while it is preempted. Sits between keypad decoder / song sequencer / mode FSM and the tone divider that drives beeper.

Parameters:
NOTE_W, 5, width of note code; code 0 = rest
GAP_CYC, 12000, silent cycles inserted on owner hand-over (1 ms at 12 MHz)
CHIRP_CYC, 600000, chirp duration in cycles (50 ms at 12 MHz)
CHIRP_NOTE, 5'd15, note code played for the chirp
MIN_HOLD_CYC, 1200000, minimum manual ownership in cycles; used only with ARB_HOLD_EN

Ports:
clk  in  1  system clock, 12 MHz
rst  in  1  asynchronous, active-high reset
chirp_trig  in  1  single-cycle pulse from mode FSM on mode change
key_valid  in  1  level; a manual key is held
key_note  in  NOTE_W  manual note code, valid while key_valid
song_req  in  1  level; song sequencer is in play mode
song_note  in  NOTE_W  current song note code
tone_en  out  1  tone generator enable
tone_note  out  NOTE_W  note code to tone generator
owner  out  2  current owner: 0 none, 1 song, 2 manual, 3 chirp
song_pause  out  1  song sequencer must hold its beat/note counters
busy  out  1  state != IDLE

Behaviour:
- Reset (asynchronous, any time, including mid-chirp or mid-gap):
  - state IDLE
  - tone_en 0, tone_note 0, owner 0, song_pause 0, busy 0
  - chirp_pending 0, counters 0
- All outputs are registered.
- States: IDLE, GAP, CHIRP, MANUAL, SONG.
- chirp_pending:
  - set by chirp_trig in any state;
  - cleared on CHIRP exit.
- IDLE (silent, so no gap needed): priority chirp_pending|chirp_trig > key_valid > song_req.
  - Enters CHIRP / MANUAL / SONG on the next edge.
  - Latency request->tone_en=1 is 1 cycle.
- GAP:
  - tone_en 0; tone_note holds the previous value; owner 0.
  - Counter runs GAP_CYC cycles.
  - On the final cycle, re-evaluates priority using the current inputs: enters the winner, or IDLE if there are no requests.
  - A request dropped during the gap is not served.
- CHIRP:
  - tone_en 1, tone_note CHIRP_NOTE, owner 3.
  - Lasts exactly CHIRP_CYC cycles.
  - chirp_trig while in CHIRP restarts the counter (retrigger; total = CHIRP_CYC from the last pulse).
  - On exit: GAP if key_valid|song_req, else IDLE.
- MANUAL:
  - owner 2; tone_note <= key_note every cycle (1-cycle latency).
  - tone_en = (key_note != 0): a rest keeps ownership silently.
  - Exit:
    - chirp_trig -> GAP.
    - key_valid falling -> GAP if song_req, else IDLE.
  - Note change while held: no gap.
- SONG:
  - owner 1; tone_note <= song_note every cycle.
  - tone_en = (song_note != 0).
  - Exit:
    - chirp_trig or key_valid -> GAP.
    - song_req falling -> IDLE.
- song_pause = song_req && next_state != SONG, registered so it aligns with owner. It is therefore 1 throughout a preemption, including the gaps before and after.
- Simultaneous chirp_trig and key_valid rise in IDLE: CHIRP wins; MANUAL follows after CHIRP and GAP if the key is still held.
- Counters are sized $clog2 of the largest count; they saturate, never wrap.

Optional Feature:
ARB_HOLD_EN
- Defined:
  - MANUAL is held for at least MIN_HOLD_CYC cycles after entry.
  - key_valid dropping earlier keeps owner 2, with tone_en 0 and tone_note 0.
  - A new key_valid within the hold resumes the tone with no gap.
  - chirp_trig still preempts immediately.
- Undefined: key_valid release exits MANUAL on the next edge; MIN_HOLD_CYC is ignored.

Test Plan (bench overrides GAP_CYC=4, CHIRP_CYC=10, MIN_HOLD_CYC=20):
- Reset, then key_valid=1, key_note=3 -> next cycle: tone_en=1, tone_note=3, owner=2, busy=1. Drop key -> next cycle IDLE, tone_en=0, owner=0.
- song_req=1, song_note=7 playing; key_valid=1, key_note=1 -> 4 cycles tone_en=0, owner=0, song_pause=1; then owner=2, tone_note=1. Release key -> 4-cycle gap, then owner=1, tone_note=7, song_pause=0.
- chirp_trig during MANUAL -> gap 4, then tone_note=15 for exactly 10 cycles. Second chirp_trig at chirp cycle 6 -> chirp ends 10 cycles after the second pulse.
- chirp_trig and key_valid rise on the same cycle in IDLE -> CHIRP first (no gap), then GAP 4, then MANUAL.
- Assert rst mid-CHIRP (cycle 5) -> tone_en=0, owner=0, song_pause=0 immediately, without waiting for a clock edge. After release with no requests -> stays IDLE.
- ARB_HOLD_EN defined: key_valid for 3 cycles -> owner=2 stays for 20 cycles, tone_en=0 after release. Undefined: owner returns to 0 one cycle after release.
